alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the 4-bit combinational datapath ALU. It executes CR16-style arithmetic, logic, shift, compare and iterative multiply on WIDTH-bit operands. It keeps a persistent 5-bit flag register so carry-chained ops work. It sits between the register-file read ports and the write-back stage, and uses a valid/ready input handshake with a one-cycle result pulse.

## Interface
- WIDTH, 16: operand/result width; legal range 4..32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- in_valid  in  1  operation request.
- in_ready  out  1  high when the block can accept an operation (state IDLE).
- opcode  in  4  operation select.
- a, b  in  WIDTH  operands (a = Rdest, b = Rsrc/shift amount).
- out_valid  out  1  one-cycle pulse when an operation completes.
- result  out  WIDTH  registered result; holds its value between pulses.
- result_we  out  1  valid with out_valid; 1 when write-back is required.
- flags  out  5  persistent flags: [0]C carry/borrow, [1]L unsigned-less, [2]F signed overflow, [3]Z zero, [4]N negative/signed-less.

## Operation
- Accept: rising edge with in_valid & in_ready. opcode, a, b and the current C are sampled only at acceptance. in_valid while in_ready=0 is ignored and not queued.
- Opcodes. Single-cycle unless marked; listed flags update, all others hold:
  - 0 ADD: a+b. C = carry-out, F = signed overflow, Z, N from result.
  - 1 ADDC: a+b+C. Flags as ADD.
  - 2 SUB: a-b. C = borrow (a<b unsigned), F = signed overflow, Z, N.
  - 3 SUBC: a-b-C. Flags as SUB.
  - 4 CMP: result_we=0, result holds. Z=(a==b), L=(a<b unsigned), N=(a<b signed). C and F hold.
  - 5 AND, 6 OR, 7 XOR, 8 NOT (~a), 9 MOV (b): Z, N from result.
  - A LSH: logical shift of a by signed b. b>0 shifts left, b<0 shifts right. |b|>=WIDTH gives 0. Z, N.
  - B ASH: as LSH, but right shifts replicate the sign. |b|>=WIDTH right gives all sign bits. Z, N.
  - C MUL (multi-cycle): shift-add, one multiplier bit per cycle, WIDTH iterations. result = low WIDTH bits of the unsigned product. C = (high half ≠ 0). Z and N from result. L and F hold.
  - D–F reserved: out_valid pulses, result_we=0, result and flags unchanged.
- FSM:
  - IDLE: in_ready=1. Accepting MUL moves to MUL with iteration count 0. Any other accepted op completes from IDLE.
  - MUL: in_ready=0. Count increments each edge. On the edge completing iteration WIDTH, return to IDLE and register the result.
- Reset: result=0, flags=0, out_valid=0, result_we=0, state IDLE, in_ready=1, count=0. Reset overrides everything, including an in-flight MUL, which is discarded with no out_valid.

## Timing
- Single-cycle ops: accepted at edge N → result, flags, out_valid, result_we valid after edge N. Latency 1 cycle.
- Back-to-back: one accept per cycle, one out_valid per cycle.
- ADDC/SUBC accepted the cycle after a flag-producing op must see that op's C. Required: flag forwarding, no bubble.
- MUL accepted at edge N:
  - in_ready low after edge N through edge N+WIDTH-1.
  - out_valid after edge N+WIDTH; latency WIDTH.
  - in_ready high after edge N+WIDTH, so the next accept can occur at N+WIDTH+1.
- out_valid is never high two cycles for one op. Each accepted op produces exactly one pulse, unless reset intervenes.
- No output backpressure; the consumer must take the result on the pulse.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, opcode ADD → out_valid=0, result=0, flags=0 throughout; in_ready=1 after release.
- Carry chain (WIDTH=16): ADD 0xFFFF+0x0001, then next cycle ADDC 0x0001+0x0001 → first result 0x0000 with C=1, Z=1, F=0, N=0; second result 0x0003 with C=0. out_valid on two consecutive cycles.
- SUB and CMP: SUB 0x8000-0x0001 → 0x7FFF, F=1, C=0, N=0. Then CMP a=0x0003, b=0xFFFF → L=1, N=0, Z=0, result_we=0, result still 0x7FFF, C and F unchanged.
- MUL: 0x0123*0x0010 → 0x1230 exactly 16 cycles after accept, in_ready low 16 cycles, in_valid pulse mid-multiply ignored. 0x0100*0x0100 → 0x0000 with C=1, Z=1.
- Shifts:
  - LSH 0x00F0 by 0xFFFC → 0x000F.
  - LSH 0x00F0 by 0x0004 → 0x0F00.
  - LSH 0x00F0 by 16 → 0x0000, Z=1.
  - ASH 0x8000 by -15 → 0xFFFF, N=1.
  - Repeat ADD 0xF+0x1 at WIDTH=4 → 0x0, C=1, Z=1.
- Reset mid-MUL: rst_n=0 on the 5th busy cycle → no out_valid, flags=0. Next ADD 2+3 → 5 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with persistent flags and an iterative
// shift-add multiplier.
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  operation request; accepted when in_ready is high
//   in_ready  high while idle
//   opcode    operation select (0..C, D..F reserved)
//   a, b      operands (a = Rdest, b = Rsrc / signed shift amount)
//   out_valid one-cycle completion pulse
//   result    registered result, held between pulses
//   result_we write-back required, qualified by out_valid
//   flags     {N, Z, F, L, C}
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic [4:0]       flags
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam int unsigned FC = 0;
    localparam int unsigned FL = 1;
    localparam int unsigned FF = 2;
    localparam int unsigned FZ = 3;
    localparam int unsigned FN = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_LSH  = 4'hA;
    localparam logic [3:0] OP_ASH  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_result_we;
    logic [WIDTH-1:0]  r_result;
    logic [4:0]        r_flags;
    logic [CW-1:0]     r_count;
    logic [W2-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [W2-1:0]     r_prod;

    logic              w_accept;
    logic              w_cin;
    logic [W1-1:0]     w_sum;
    logic [W1-1:0]     w_diff;
    logic              w_neg;
    logic [WIDTH-1:0]  w_mag;
    logic              w_big;
    logic [SW-1:0]     w_sh;
    logic [WIDTH-1:0]  w_res;
    logic              w_res_upd;
    logic              w_we;
    logic              w_zn_upd;
    logic [4:0]        w_flags;
    logic [W2-1:0]     w_prod_nx;
    logic [WIDTH-1:0]  w_mul_res;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_we = r_result_we;
    assign flags     = r_flags;

    assign w_accept = in_valid && r_in_ready;

    // Carry-in comes straight from the flag register, which the previous op
    // has already updated on its completing edge, so chained ops need no bubble.
    assign w_cin  = ((opcode == OP_ADDC) || (opcode == OP_SUBC)) ? r_flags[FC] : 1'b0;
    assign w_sum  = {1'b0, a} + {1'b0, b} + W1'(w_cin);
    assign w_diff = {1'b0, a} - {1'b0, b} - W1'(w_cin);

    // Signed shift amount split into direction and magnitude.
    assign w_neg = b[WIDTH-1];
    assign w_mag = w_neg ? (~b + ONE) : b;
    assign w_big = (w_mag >= WIDTH'(WIDTH));
    assign w_sh  = w_mag[SW-1:0];

    // One shift-add iteration of the multiplier.
    assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_res = w_prod_nx[WIDTH-1:0];

    // Single-cycle datapath and flag update.
    always_comb begin
        w_res     = r_result;
        w_res_upd = 1'b1;
        w_we      = 1'b1;
        w_zn_upd  = 1'b1;
        w_flags   = r_flags;
        case (opcode)
            OP_ADD, OP_ADDC: begin
                w_res       = w_sum[WIDTH-1:0];
                w_flags[FC] = w_sum[WIDTH];
                w_flags[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                w_res       = w_diff[WIDTH-1:0];
                w_flags[FC] = w_diff[WIDTH];
                w_flags[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                w_res_upd   = 1'b0;
                w_we        = 1'b0;
                w_zn_upd    = 1'b0;
                w_flags[FZ] = (a == b);
                w_flags[FL] = (a < b);
                w_flags[FN] = ($signed(a) < $signed(b));
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_MOV: w_res = b;
            OP_LSH: begin
                if (w_big)      w_res = '0;
                else if (w_neg) w_res = a >> w_sh;
                else            w_res = a << w_sh;
            end
            OP_ASH: begin
                if (w_neg) w_res = w_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> w_sh);
                else       w_res = w_big ? '0 : (a << w_sh);
            end
            default: begin
                // Reserved codes: pulse only, nothing architectural changes.
                w_res_upd = 1'b0;
                w_we      = 1'b0;
                w_zn_upd  = 1'b0;
            end
        endcase
        if (w_zn_upd) begin
            w_flags[FZ] = (w_res == '0);
            w_flags[FN] = w_res[WIDTH-1];
        end
    end

    // Control FSM, multiplier iteration and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result_we <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_count     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_result_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (opcode == OP_MUL) begin
                            r_state    <= ST_MUL;
                            r_in_ready <= 1'b0;
                            r_count    <= '0;
                            r_mcand    <= {{WIDTH{1'b0}}, a};
                            r_mplier   <= b;
                            r_prod     <= '0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result_we <= w_we;
                            r_flags     <= w_flags;
                            if (w_res_upd) r_result <= w_res;
                        end
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod_nx;
                    r_mcand  <= {r_mcand[W2-2:0], 1'b0};
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_result_we <= 1'b1;
                        r_result    <= w_mul_res;
                        r_flags[FC] <= (w_prod_nx[W2-1:WIDTH] != '0);
                        r_flags[FZ] <= (w_mul_res == '0);
                        r_flags[FN] <= w_mul_res[WIDTH-1];
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16 and WIDTH=4).
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;
    logic        result_we;
    logic [4:0]  flags;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  opcode4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        out_valid4;
    logic [3:0]  result4;
    logic        result_we4;
    logic [4:0]  flags4;

    int total = 0;
    int bad   = 0;
    int busy_low;
    int pulses;

    alu_seq #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .result(result),
        .result_we(result_we), .flags(flags)
    );

    alu_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .opcode(opcode4), .a(a4), .b(b4), .out_valid(out_valid4), .result(result4),
        .result_we(result_we4), .flags(flags4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
    endtask

    // flags layout {N, Z, F, L, C}
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1; opcode = 4'h0; a = 16'h0001; b = 16'h0001;
        in_valid4 = 1'b0; opcode4 = 4'h0; a4 = 4'h0; b4 = 4'h0;

        // Reset held two cycles with a pending ADD request
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_result",    32'(result),    32'd0);
            chk("rst_flags",     32'(flags),     32'd0);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Carry chain: ADD then ADDC back to back
        drive(4'h0, 16'hFFFF, 16'h0001);
        tick();
        chk("add_valid",  32'(out_valid), 32'd1);
        chk("add_result", 32'(result),    32'h0000);
        chk("add_flags",  32'(flags),     32'b01001);
        chk("add_we",     32'(result_we), 32'd1);
        drive(4'h1, 16'h0001, 16'h0001);
        tick();
        chk("addc_valid",  32'(out_valid), 32'd1);
        chk("addc_result", 32'(result),    32'h0003);
        chk("addc_flags",  32'(flags),     32'b00000);

        // SUB with signed overflow, then CMP
        drive(4'h2, 16'h8000, 16'h0001);
        tick();
        chk("sub_result", 32'(result), 32'h7FFF);
        chk("sub_flags",  32'(flags),  32'b00100);
        drive(4'h4, 16'h0003, 16'hFFFF);
        tick();
        chk("cmp_valid",  32'(out_valid), 32'd1);
        chk("cmp_we",     32'(result_we), 32'd0);
        chk("cmp_result", 32'(result),    32'h7FFF);
        chk("cmp_flags",  32'(flags),     32'b00110);
        in_valid = 1'b0;
        tick();
        chk("cmp_single_pulse", 32'(out_valid), 32'd0);

        // MUL 0x0123 * 0x0010 with a stray request mid-multiply
        drive(4'hC, 16'h0123, 16'h0010);
        tick();
        in_valid = 1'b0;
        busy_low = (in_ready == 1'b0) ? 1 : 0;
        pulses   = (out_valid == 1'b1) ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            if (i == 5) drive(4'h0, 16'h1111, 16'h2222);
            if (i == 6) in_valid = 1'b0;
            tick();
            if (in_ready == 1'b0) busy_low++;
            if (out_valid == 1'b1) pulses++;
        end
        chk("mul_busy_cycles", 32'(busy_low), 32'd16);
        chk("mul_early_pulse", 32'(pulses),   32'd0);
        tick();
        chk("mul_valid",    32'(out_valid), 32'd1);
        chk("mul_result",   32'(result),    32'h1230);
        chk("mul_flags",    32'(flags),     32'b00110);
        chk("mul_ready",    32'(in_ready),  32'd1);
        tick();
        chk("mul_no_extra", 32'(out_valid), 32'd0);

        // MUL with overflow into the high half
        drive(4'hC, 16'h0100, 16'h0100);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        tick();
        chk("mul2_valid",  32'(out_valid), 32'd1);
        chk("mul2_result", 32'(result),    32'h0000);
        chk("mul2_flags",  32'(flags),     32'b01111);

        // Shifts, back to back
        drive(4'hA, 16'h00F0, 16'hFFFC);
        tick();
        chk("lsh_r_result", 32'(result), 32'h000F);
        chk("lsh_r_flags",  32'(flags),  32'b00111);
        drive(4'hA, 16'h00F0, 16'h0004);
        tick();
        chk("lsh_l_result", 32'(result), 32'h0F00);
        drive(4'hA, 16'h00F0, 16'd16);
        tick();
        chk("lsh_big_result", 32'(result), 32'h0000);
        chk("lsh_big_flags",  32'(flags),  32'b01111);
        drive(4'hB, 16'h8000, 16'hFFF1);
        tick();
        chk("ash_result", 32'(result),    32'hFFFF);
        chk("ash_flags",  32'(flags),     32'b10111);
        chk("ash_valid",  32'(out_valid), 32'd1);
        in_valid = 1'b0;

        // WIDTH=4 carry out
        in_valid4 = 1'b1; opcode4 = 4'h0; a4 = 4'hF; b4 = 4'h1;
        tick();
        in_valid4 = 1'b0;
        chk("w4_valid",  32'(out_valid4), 32'd1);
        chk("w4_result", 32'(result4),    32'h0);
        chk("w4_flags",  32'(flags4),     32'b01001);

        // Reset on the 5th busy cycle of a MUL
        drive(4'hC, 16'h0003, 16'h0005);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmul_valid",  32'(out_valid), 32'd0);
        chk("rmul_flags",  32'(flags),     32'd0);
        chk("rmul_result", 32'(result),    32'd0);
        chk("rmul_ready",  32'(in_ready),  32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid == 1'b1) pulses++;
        end
        chk("rmul_no_pulse", 32'(pulses), 32'd0);
        drive(4'h0, 16'h0002, 16'h0003);
        tick();
        in_valid = 1'b0;
        chk("post_add_valid",  32'(out_valid), 32'd1);
        chk("post_add_result", 32'(result),    32'h0005);
        chk("post_add_flags",  32'(flags),     32'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
